message_scroller: RTL

//   Reads a 16-entry x 8-bit ASCII message ROM and builds a NUM_DIGITS-character

---
 rtl/message_scroller_if.sv | 25 ++
 rtl/message_scroller.sv | 104 ++++++++++
 2 files changed

// File: rtl/message_scroller_if.sv
// Signal bundle between the message scroller, its character ROM and the display.
// master = scroller side, slave = ROM/display/control side.
interface message_scroller_if #(
  parameter int NUM_DIGITS = 6,
  parameter int ADDR_W     = 4
);
  logic                    enable;
  logic                    dir;
  logic [7:0]              rom_data;
  logic [ADDR_W-1:0]       rom_addr;
  logic [8*NUM_DIGITS-1:0] window;
  logic                    window_valid;
  logic                    frame_strobe;
  logic [ADDR_W-1:0]       pos;

  modport master (
    input  enable, dir, rom_data,
    output rom_addr, window, window_valid, frame_strobe, pos
  );

  modport slave (
    output enable, dir, rom_data,
    input  rom_addr, window, window_valid, frame_strobe, pos
  );
endinterface

// File: rtl/message_scroller.sv
// Scrolls a NUM_DIGITS-character window across a 2**ADDR_W-entry ASCII ROM,
// loading each new window into a shadow buffer and committing it atomically.
module message_scroller #(
  parameter int CLK_DIV    = 25_000_000,
  parameter int NUM_DIGITS = 6,
  parameter int ADDR_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  message_scroller_if.master bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [8*NUM_DIGITS-1:0] BLANK = {NUM_DIGITS{8'h20}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    tick;
  logic [IDX_W-1:0]        idx;
  logic [ADDR_W-1:0]       pos_q;
  logic [8*NUM_DIGITS-1:0] shadow;
  logic [8*NUM_DIGITS-1:0] window_q;
  logic                    valid_q;
  logic                    strobe_q;
  logic [ADDR_W-1:0]       addr_c;

  // Free-running tick divider; holds (not clears) while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.enable) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = bus.enable && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      pos_q    <= '0;
      idx      <= '0;
      shadow   <= BLANK;
      window_q <= BLANK;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            pos_q <= bus.dir ? pos_q - ADDR_W'(1) : pos_q + ADDR_W'(1);
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          // Digit 0 lives in the most significant byte of the window.
          for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
              shadow[8*(NUM_DIGITS-1-d) +: 8] <= bus.rom_data;
            end
          end
          if (idx == IDX_LAST) begin
            state <= COMMIT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        COMMIT: begin
          window_q <= shadow;
          strobe_q <= 1'b1;
          valid_q  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ROM is combinational, so the address must track the current load slot.
  always_comb begin
    addr_c = pos_q;
    if (state == LOAD) begin
      addr_c = pos_q + ADDR_W'(idx);
    end
  end

  assign bus.rom_addr     = addr_c;
  assign bus.window       = window_q;
  assign bus.window_valid = valid_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.pos          = pos_q;

endmodule
